// File: rtl/jtag_master.sv
// Host-side JTAG master: turns DR/IR scan, TAP reset and idle-clock commands
// into tck/tms/tdi sequences and collects tdo. The TAP always ends in Run-Test/Idle.
module jtag_master #(
  parameter int CLK_DIV = 2,
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_type,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               busy,
  output logic               tck,
  output logic               tms,
  output logic               tdi,
  input  logic               tdo
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam logic [3:0] INIT_RST = 4'd0;
  localparam logic [3:0] IDLE     = 4'd1;
  localparam logic [3:0] NAV_IR   = 4'd2;
  localparam logic [3:0] NAV      = 4'd3;
  localparam logic [3:0] SHIFT    = 4'd4;
  localparam logic [3:0] EXIT     = 4'd5;
  localparam logic [3:0] RTI      = 4'd6;
  localparam logic [3:0] RUN      = 4'd7;
  localparam logic [3:0] DONE     = 4'd8;

  logic [3:0]         state, nxt_state;
  logic [LEN_W-1:0]   cnt, nxt_cnt, len_m1, n_eff;
  logic [DIV_W-1:0]   div;
  logic [MAX_LEN-1:0] data_sr, cap;
  logic               rsp_en, nxt_tms, load_bit;
  logic               active, tick, rise, fall;

  assign busy   = ~cmd_ready;
  assign active = (state != IDLE) && (state != DONE);
  assign tick   = active && (div == DIV_W'(CLK_DIV - 1));
  assign rise   = tick && !tck;
  assign fall   = tick && tck;

  always_comb begin
    n_eff = cmd_len;
    if (cmd_len == '0)
      n_eff = LEN_W'(1);
    else if (cmd_len > LEN_W'(MAX_LEN))
      n_eff = LEN_W'(MAX_LEN);
  end

  // Decides the tms/state of the tck that starts at the current falling edge.
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt + 1'b1;
    nxt_tms   = 1'b0;
    load_bit  = 1'b0;
    case (state)
      INIT_RST: begin
        if (cnt == LEN_W'(5)) begin
          nxt_state = DONE;
          nxt_cnt   = '0;
        end else begin
          nxt_tms = (cnt != LEN_W'(4));
        end
      end
      NAV_IR: begin
        nxt_state = NAV;
        nxt_cnt   = '0;
        nxt_tms   = 1'b1;
      end
      NAV: begin
        if (cnt == LEN_W'(2)) begin
          nxt_state = SHIFT;
          nxt_cnt   = '0;
          nxt_tms   = (len_m1 == '0);
          load_bit  = 1'b1;
        end
      end
      SHIFT: begin
        if (cnt == len_m1) begin
          nxt_state = EXIT;
          nxt_cnt   = '0;
          nxt_tms   = 1'b1;
        end else begin
          nxt_tms  = ((cnt + 1'b1) == len_m1);
          load_bit = 1'b1;
        end
      end
      EXIT: begin
        nxt_state = RTI;
        nxt_cnt   = '0;
      end
      RTI: begin
        nxt_state = DONE;
        nxt_cnt   = '0;
      end
      RUN: begin
        if (cnt == len_m1) begin
          nxt_state = DONE;
          nxt_cnt   = '0;
        end
      end
      default: begin
        nxt_cnt = cnt;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= INIT_RST;
      cnt       <= '0;
      div       <= '0;
      len_m1    <= '0;
      data_sr   <= '0;
      cap       <= '0;
      rsp_en    <= 1'b0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      tck       <= 1'b0;
      tms       <= 1'b1;
      tdi       <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      if (active)
        div <= tick ? '0 : div + 1'b1;
      if (tick)
        tck <= ~tck;
      if (rise && state == SHIFT)
        cap[cnt[IDX_W-1:0]] <= tdo;
      if (fall) begin
        state <= nxt_state;
        cnt   <= nxt_cnt;
        tms   <= nxt_tms;
        tdi   <= load_bit ? data_sr[0] : 1'b0;
        if (load_bit)
          data_sr <= data_sr >> 1;
      end
      // Command accept sets up the first tck; completion publishes the capture.
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            div       <= '0;
            cnt       <= '0;
            cap       <= '0;
            data_sr   <= cmd_data;
            len_m1    <= n_eff - 1'b1;
            rsp_en    <= 1'b1;
            tdi       <= 1'b0;
            case (cmd_type)
              2'b00: begin state <= NAV;      tms <= 1'b1; end
              2'b01: begin state <= NAV_IR;   tms <= 1'b1; end
              2'b10: begin state <= INIT_RST; tms <= 1'b1; end
              default: begin state <= RUN;    tms <= 1'b0; end
            endcase
          end
        end
        DONE: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          if (rsp_en) begin
            rsp_valid <= 1'b1;
            rsp_data  <= cap;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_master.sv
// Directed bench for jtag_master: logs tms/tdi at every rising tck and
// compares sequences, counts and captured data against hand-computed values.
module tb_jtag_master;
  localparam int CLK_DIV = 2;
  localparam int MAX_LEN = 32;
  localparam int LEN_W   = 6;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  logic [1:0]         cmd_type = '0;
  logic [LEN_W-1:0]   cmd_len = '0;
  logic [MAX_LEN-1:0] cmd_data = '0;
  logic               rsp_valid;
  logic [MAX_LEN-1:0] rsp_data;
  logic               busy, tck, tms, tdi, tdo;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  jtag_master #(.CLK_DIV(CLK_DIV), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_type(cmd_type), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
    .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo)
  );

  // tck-edge log of what the TAP would see
  int   tckCount = 0;
  logic tmsLog [0:2047];
  logic tdiLog [0:2047];
  always @(posedge tck) begin
    tmsLog[tckCount] <= tms;
    tdiLog[tckCount] <= tdi;
    tckCount <= tckCount + 1;
  end

  // clk-cycle monitor for response pulses and edge timing
  int          cyc = 0, rspCount = 0, rspCyc = 0;
  int          lastFallCyc = 0, lastRiseCyc = 0, readyRiseCyc = 0;
  logic [31:0] lastRsp = '0;
  logic        prevTck = 1'b0, prevReady = 1'b0;
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (prevTck && !tck) lastFallCyc <= cyc;
    if (!prevTck && tck) lastRiseCyc <= cyc;
    if (!prevReady && cmd_ready) readyRiseCyc <= cyc;
    if (rsp_valid) begin
      rspCount <= rspCount + 1;
      lastRsp  <= rsp_data;
      rspCyc   <= cyc;
    end
    prevTck   <= tck;
    prevReady <= cmd_ready;
  end

  // Target model: constant tdo, or a preloaded register presented from shift tck 4 onward
  logic        tdoMode = 1'b0;
  logic        tdoConst = 1'b0;
  logic [31:0] tdoPre = '0;
  int          tckStart = 0;
  int          rel;
  always_comb begin
    rel = tckCount - tckStart - 3;
    tdo = tdoConst;
    if (tdoMode)
      tdo = (rel >= 0 && rel < 32) ? tdoPre[rel[4:0]] : 1'b0;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] logBits(input int start, input int n, input bit useTdi);
    logic [63:0] v;
    v = '0;
    for (int k = 0; k < n && k < 64; k++)
      v[k] = useTdi ? tdiLog[start + k] : tmsLog[start + k];
    return v;
  endfunction

  task automatic waitReady(input string tag);
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk); #1;
      if (cmd_ready) break;
    end
    checkOutput({tag, "_ready"}, 64'(cmd_ready), 64'd1);
  endtask

  task automatic waitRsp(input string tag, input int startRsp);
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk); #1;
      if (rspCount != startRsp) break;
    end
    checkOutput({tag, "_rsp"}, 64'(rspCount), 64'(startRsp + 1));
  endtask

  task automatic applyStimulus(input logic [1:0] t, input logic [LEN_W-1:0] len,
                               input logic [31:0] data, output int startTck, output int startRsp);
    waitReady("issue");
    cmd_type  = t;
    cmd_len   = len;
    cmd_data  = data;
    cmd_valid = 1'b1;
    startRsp  = rspCount;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    startTck  = tckCount;
    tckStart  = tckCount;
  endtask

  int s, r, s2, r2, rel0;

  initial begin
    // reset values
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_tck", 64'(tck), 64'd0);
    checkOutput("rst_tms", 64'(tms), 64'd1);
    checkOutput("rst_tdi", 64'(tdi), 64'd0);
    checkOutput("rst_ready", 64'(cmd_ready), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd1);
    checkOutput("rst_rspv", 64'(rsp_valid), 64'd0);
    checkOutput("rst_rspd", 64'(rsp_data), 64'd0);

    // automatic init sequence
    s = tckCount;
    rst_n = 1'b1;
    waitReady("init");
    checkOutput("init_tcks", 64'(tckCount - s), 64'd6);
    checkOutput("init_tms", logBits(s, 6, 0), 64'h1F);
    checkOutput("init_tdi", logBits(s, 6, 1), 64'h0);
    checkOutput("init_ready_lat", 64'(readyRiseCyc - lastFallCyc), 64'd1);
    checkOutput("init_no_rsp", 64'(rspCount), 64'd0);

    // DR len 8, data 0xA5, target shifts out 0x3C
    tdoMode = 1'b1;
    tdoPre  = 32'h3C;
    applyStimulus(2'b00, 6'd8, 32'hA5, s, r);
    waitRsp("dr8", r);
    checkOutput("dr8_tcks", 64'(tckCount - s), 64'd13);
    checkOutput("dr8_tms", logBits(s, 13, 0), 64'h0C01);
    checkOutput("dr8_tdi", logBits(s, 13, 1), 64'h0528);
    checkOutput("dr8_data", 64'(lastRsp), 64'h3C);

    // IR len 4, data 0xE, tdo tied high
    tdoMode  = 1'b0;
    tdoConst = 1'b1;
    applyStimulus(2'b01, 6'd4, 32'hE, s, r);
    waitRsp("ir4", r);
    checkOutput("ir4_tcks", 64'(tckCount - s), 64'd10);
    checkOutput("ir4_tms", logBits(s, 10, 0), 64'h183);
    checkOutput("ir4_tdi", logBits(s, 10, 1), 64'hE0);
    checkOutput("ir4_data", 64'(lastRsp), 64'hF);

    // DR len 0 behaves as len 1
    applyStimulus(2'b00, 6'd0, 32'h1, s, r);
    waitRsp("dr0", r);
    checkOutput("dr0_tcks", 64'(tckCount - s), 64'd6);
    checkOutput("dr0_tms", logBits(s, 6, 0), 64'h19);
    checkOutput("dr0_tdi", logBits(s, 6, 1), 64'h8);
    checkOutput("dr0_data", 64'(lastRsp), 64'h1);

    // DR len 40 clamps to 32
    applyStimulus(2'b00, 6'd40, 32'h0, s, r);
    waitRsp("dr40", r);
    checkOutput("dr40_tcks", 64'(tckCount - s), 64'd37);
    checkOutput("dr40_tms", logBits(s, 37, 0), 64'hC_0000_0001);
    checkOutput("dr40_data", 64'(lastRsp), 64'hFFFF_FFFF);

    // idle clocks
    applyStimulus(2'b11, 6'd3, 32'hFF, s, r);
    waitRsp("idle3", r);
    checkOutput("idle3_tcks", 64'(tckCount - s), 64'd3);
    checkOutput("idle3_tms", logBits(s, 3, 0), 64'h0);
    checkOutput("idle3_tdi", logBits(s, 3, 1), 64'h0);
    checkOutput("idle3_data", 64'(lastRsp), 64'h0);
    checkOutput("idle_tms", 64'(tms), 64'd0);

    // back-to-back DR len 2 with cmd_valid held high
    waitReady("b2b");
    cmd_type  = 2'b00;
    cmd_len   = 6'd2;
    cmd_data  = 32'h1;
    cmd_valid = 1'b1;
    r = rspCount;
    @(posedge clk); #1;
    s = tckCount;
    tckStart = tckCount;
    cmd_data = 32'h2;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk); #1;
      if (rspCount != r) break;
    end
    checkOutput("b2b_first_rsp", 64'(rspCount), 64'(r + 1));
    checkOutput("b2b_first_tcks", 64'(tckCount - s), 64'd7);
    checkOutput("b2b_first_tdi", logBits(s, 7, 1), 64'h8);
    checkOutput("b2b_ready_in_rsp", 64'(cmd_ready), 64'd1);
    r2 = rspCount;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    s2 = tckCount;
    tckStart = tckCount;
    checkOutput("b2b_second_taken", 64'(cmd_ready), 64'd0);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk); #1;
      if (tckCount != s2) break;
    end
    @(negedge clk); #1;
    checkOutput("b2b_gap", 64'(lastRiseCyc - rspCyc), 64'(CLK_DIV + 1));
    waitRsp("b2b_second", r2);
    checkOutput("b2b_second_tms", logBits(s2, 7, 0), 64'h31);
    checkOutput("b2b_second_tdi", logBits(s2, 7, 1), 64'h10);
    checkOutput("b2b_second_data", 64'(lastRsp), 64'h3);

    // reset during shift bit 5 of a DR len 16
    applyStimulus(2'b00, 6'd16, 32'hFFFF, s, r);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk); #1;
      if (tckCount >= s + 9) break;
    end
    checkOutput("abort_reached", 64'(tckCount - s), 64'd9);
    rst_n = 1'b0;
    @(negedge clk); #1;
    checkOutput("abort_tck", 64'(tck), 64'd0);
    checkOutput("abort_tms", 64'(tms), 64'd1);
    checkOutput("abort_busy", 64'(busy), 64'd1);
    rst_n = 1'b1;
    rel0 = tckCount;
    waitReady("abort_init");
    checkOutput("abort_init_tcks", 64'(tckCount - rel0), 64'd6);
    checkOutput("abort_init_tms", logBits(rel0, 6, 0), 64'h1F);
    checkOutput("abort_no_rsp", 64'(rspCount), 64'(r));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
